// File: rtl/afe_spi_pkg.sv
// Shared encodings for the AFE serial programming engine: FSM states, status/CSR bit
// positions and default geometry.
package afe_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LE_SETUP = 3'd3,
    ST_LE_PULSE = 3'd4,
    ST_GAP      = 3'd5
  } afe_state_e;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_OVERRUN   = 1;
  localparam int unsigned STAT_BADSEL    = 2;
  localparam int unsigned CSR_CLR        = 30;

  localparam int unsigned DEF_CLK_DIV    = 4;
  localparam int unsigned DEF_WORD_WIDTH = 24;

endpackage

// File: rtl/afe_spi_tick.sv
// CLK_DIV prescaler: registered one-cycle tick on the last cycle of every FSM state,
// realigned to the state boundary by start_i.
module afe_spi_tick
  import afe_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = '0;
    if (!start_i && en_i && (cnt_q != CNT_W'(CLK_DIV - 1))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_W'(CLK_DIV - 1));
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/afe_spi_driver.sv
// Serial programming engine for the AFE boards: shifts one CSR word MSB-first to one lane.
// Optional AFE_SPI_SHADOW_EN adds a per-lane copy of the last fully latched word.
module afe_spi_driver
  import afe_spi_pkg::*;
#(
  parameter int unsigned N_AFE      = 2,
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned SEL_WIDTH  = 1
) (
  input  logic                          sysClk,
  input  logic                          sysReset,
  input  logic                          csrStrobe,
  input  logic [31:0]                   csrData,
  output logic [31:0]                   status,
  output logic [N_AFE-1:0]              spiClk,
  output logic [N_AFE-1:0]              spiSdi,
  output logic [N_AFE-1:0]              spiLe
`ifdef AFE_SPI_SHADOW_EN
  ,
  output logic [N_AFE*WORD_WIDTH-1:0]   shadow
`endif
);

  localparam int unsigned BIT_W = $clog2(WORD_WIDTH);

  afe_state_e            state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d, csr_sel;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  badsel_q, badsel_d;
  logic [N_AFE-1:0]      clk_q, clk_d, sdi_q, sdi_d, le_q, le_d, lane_c;
  logic                  tick, accept_c, last_gap_c, sel_ok_c, csr_unused_c;

  assign csr_sel      = csrData[31 -: SEL_WIDTH];
  assign sel_ok_c     = (32'(csr_sel) < N_AFE);
  assign last_gap_c   = (state_q == ST_GAP) && tick;
  assign csr_unused_c = ^csrData;

  afe_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i   (sysClk),
    .rst_i   (sysReset),
    .start_i (accept_c),
    .en_i    (busy_q),
    .tick_o  (tick)
  );

  // A strobe in the final GAP cycle starts the next word back-to-back with no idle cycle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    sel_d     = sel_q;
    overrun_d = overrun_q;
    badsel_d  = badsel_q;
    accept_c  = 1'b0;
    lane_c    = '0;
    clk_d     = '0;
    sdi_d     = '0;
    le_d      = '0;
    busy_d    = 1'b0;

    case (state_q)
      ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (tick) begin
          if (bit_q == '0) begin
            state_d = ST_LE_SETUP;
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            shreg_d = {shreg_q[WORD_WIDTH-2:0], 1'b0};
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_LE_SETUP: if (tick) state_d = ST_LE_PULSE;
      ST_LE_PULSE: if (tick) state_d = ST_GAP;
      ST_GAP:      if (tick) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (csrStrobe) begin
      if ((state_q != ST_IDLE) && !last_gap_c) begin
        overrun_d = 1'b1;
      end else if (!sel_ok_c) begin
        badsel_d = 1'b1;
      end else begin
        accept_c = 1'b1;
        state_d  = ST_SHIFT_LO;
        shreg_d  = csrData[WORD_WIDTH-1:0];
        bit_d    = BIT_W'(WORD_WIDTH - 1);
        sel_d    = csr_sel;
        if (csrData[CSR_CLR]) begin
          overrun_d = 1'b0;
          badsel_d  = 1'b0;
        end
      end
    end

    for (int unsigned i = 0; i < N_AFE; i++) begin
      lane_c[i] = (32'(sel_d) == i);
    end

    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_SHIFT_HI) clk_d = lane_c;
    if (((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) && shreg_d[WORD_WIDTH-1]) begin
      sdi_d = lane_c;
    end
    if (state_d == ST_LE_PULSE) le_d = lane_c;
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      badsel_q  <= 1'b0;
      clk_q     <= '0;
      sdi_q     <= '0;
      le_q      <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      badsel_q  <= badsel_d;
      clk_q     <= clk_d;
      sdi_q     <= sdi_d;
      le_q      <= le_d;
    end
  end

  assign spiClk = clk_q;
  assign spiSdi = sdi_q;
  assign spiLe  = le_q;

  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = busy_q;
    status[STAT_OVERRUN] = overrun_q;
    status[STAT_BADSEL]  = badsel_q;
  end

`ifdef AFE_SPI_SHADOW_EN
  logic [WORD_WIDTH-1:0]       word_q;
  logic [N_AFE*WORD_WIDTH-1:0] shadow_q;

  // Shadow commits only once the LE pulse has completed, so aborted words never land.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      word_q   <= '0;
      shadow_q <= '0;
    end else begin
      if (accept_c) word_q <= csrData[WORD_WIDTH-1:0];
      if ((state_q == ST_LE_PULSE) && tick) begin
        for (int unsigned i = 0; i < N_AFE; i++) begin
          if (32'(sel_q) == i) shadow_q[i*WORD_WIDTH +: WORD_WIDTH] <= word_q;
        end
      end
    end
  end

  assign shadow = shadow_q;
`endif

endmodule

// File: tb/tb_afe_spi_driver.sv
// Bench for afe_spi_driver: cycle-level transaction model plus directed scenarios;
// also builds with AFE_SPI_SHADOW_EN to check the shadow port.
module tb_afe_spi_driver;

  localparam int unsigned W        = 24;
  localparam int unsigned D        = 4;
  localparam int unsigned NA       = 2;
  localparam int unsigned BUSY_LEN = (2*W + 3) * D;

  logic          clk = 1'b0;
  logic          rst;
  logic          strobe, strobe2;
  logic [31:0]   data, data2;
  logic [31:0]   status, status2;
  logic [NA-1:0] spi_clk, spi_sdi, spi_le;
  logic [2:0]    spi_clk2, spi_sdi2, spi_le2;
`ifdef AFE_SPI_SHADOW_EN
  logic [NA*W-1:0] shadow;
  logic [3*W-1:0]  shadow2;
`endif

  int unsigned n_vec, n_err;
  bit          cmp_en;

  always #5 clk = ~clk;

  afe_spi_driver #(.N_AFE(NA), .WORD_WIDTH(W), .CLK_DIV(D), .SEL_WIDTH(1)) dut (
    .sysClk(clk), .sysReset(rst), .csrStrobe(strobe), .csrData(data), .status(status),
    .spiClk(spi_clk), .spiSdi(spi_sdi), .spiLe(spi_le)
`ifdef AFE_SPI_SHADOW_EN
    , .shadow(shadow)
`endif
  );

  afe_spi_driver #(.N_AFE(3), .WORD_WIDTH(W), .CLK_DIV(D), .SEL_WIDTH(2)) dut2 (
    .sysClk(clk), .sysReset(rst), .csrStrobe(strobe2), .csrData(data2), .status(status2),
    .spiClk(spi_clk2), .spiSdi(spi_sdi2), .spiLe(spi_le2)
`ifdef AFE_SPI_SHADOW_EN
    , .shadow(shadow2)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: k counts cycles since accept; a word occupies BUSY_LEN cycles.
  bit              m_act, m_ovr, m_bad;
  int unsigned     m_k, m_lane;
  logic [W-1:0]    m_word;
  logic [NA*W-1:0] m_shadow;

  always @(posedge clk or posedge rst) begin : model
    bit          act;
    int unsigned k;
    int unsigned idx;
    if (rst) begin
      m_act    <= 1'b0;
      m_k      <= 0;
      m_ovr    <= 1'b0;
      m_bad    <= 1'b0;
      m_shadow <= '0;
    end else begin
      act = m_act;
      k   = m_k;
      if (act) begin
        if (k == (2*W + 2)*D - 1) m_shadow[m_lane*W +: W] <= m_word;
        if (k == BUSY_LEN - 1) act = 1'b0;
        else k = k + 1;
      end
      if (strobe) begin
        idx = 32'(data[31]);
        if (act) m_ovr <= 1'b1;
        else if (idx >= NA) m_bad <= 1'b1;
        else begin
          act    = 1'b1;
          k      = 0;
          m_word <= data[W-1:0];
          m_lane <= idx;
          if (data[30]) begin
            m_ovr <= 1'b0;
            m_bad <= 1'b0;
          end
        end
      end
      m_act <= act;
      m_k   <= k;
    end
  end

  always @(negedge clk) begin : cmp
    logic [NA-1:0] ec, es, el;
    int unsigned   p;
    if (cmp_en) begin
      ec = '0;
      es = '0;
      el = '0;
      if (m_act) begin
        p = m_k / D;
        if (p < 2*W) begin
          ec[m_lane] = (p % 2 == 1);
          es[m_lane] = m_word[W - 1 - p/2];
        end else if (p == 2*W + 1) begin
          el[m_lane] = 1'b1;
        end
      end
      chk("status", 64'(status), {32'd0, 29'd0, m_bad, m_ovr, m_act});
      chk("pins", 64'({spi_clk, spi_sdi, spi_le}), 64'({ec, es, el}));
`ifdef AFE_SPI_SHADOW_EN
      chk("shadow", 64'(shadow), 64'(m_shadow));
`endif
    end
  end

  // Pin-level observations for the literal checks.
  int unsigned   rises[NA], le_cnt[NA], act_cnt[NA], age[NA], min_setup[NA];
  int unsigned   busy_cnt, busy_falls;
  logic [63:0]   cap[NA];
  logic [NA-1:0] prv_clk, prv_sdi;
  logic          prv_busy;

  always @(negedge clk) begin
    for (int i = 0; i < NA; i++) begin
      if (spi_sdi[i] !== prv_sdi[i]) age[i] = 1;
      else age[i] = age[i] + 1;
      if (spi_clk[i] && !prv_clk[i]) begin
        rises[i]++;
        cap[i] = {cap[i][62:0], spi_sdi[i]};
        if (age[i] - 1 < min_setup[i]) min_setup[i] = age[i] - 1;
      end
      if (spi_le[i]) le_cnt[i]++;
      if (spi_clk[i] || spi_sdi[i] || spi_le[i]) act_cnt[i]++;
    end
    if (status[0]) busy_cnt++;
    if (!status[0] && prv_busy) busy_falls++;
    prv_clk  = spi_clk;
    prv_sdi  = spi_sdi;
    prv_busy = status[0];
  end

  task automatic mon_clear();
    for (int i = 0; i < NA; i++) begin
      rises[i]     = 0;
      le_cnt[i]    = 0;
      act_cnt[i]   = 0;
      age[i]       = 0;
      min_setup[i] = 1000;
      cap[i]       = '0;
    end
    busy_cnt   = 0;
    busy_falls = 0;
    prv_clk    = spi_clk;
    prv_sdi    = spi_sdi;
    prv_busy   = status[0];
  endtask

  task automatic pulse(input logic [31:0] d);
    strobe = 1'b1;
    data   = d;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    data   = '0;
  endtask

  task automatic pulse2(input logic [31:0] d);
    strobe2 = 1'b1;
    data2   = d;
    @(posedge clk);
    #1;
    strobe2 = 1'b0;
    data2   = '0;
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; data = '0; strobe2 = 1'b0; data2 = '0;
    cmp_en = 1'b0; n_vec = 0; n_err = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_status", 64'(status), 64'd0);
    chk("reset_pins", 64'({spi_clk, spi_sdi, spi_le}), 64'd0);

    // Lane 0, payload 0xA55A5A
    @(posedge clk); #1;
    mon_clear();
    pulse(32'h00A5_5A5A);
    @(negedge clk);
    chk("t1_first_status", 64'(status), 64'd1);
    chk("t1_first_sdi", 64'(spi_sdi), 64'd1);
    chk("t1_first_sclk", 64'(spi_clk), 64'd0);
    repeat (210) @(posedge clk); #1;
    chk("t1_rises", 64'(rises[0]), 64'd24);
    chk("t1_word", cap[0] & 64'hFF_FFFF, 64'hA5_5A5A);
    chk("t1_le_cycles", 64'(le_cnt[0]), 64'd4);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd204);
    chk("t1_lane1_quiet", 64'(act_cnt[1]), 64'd0);
`ifdef AFE_SPI_SHADOW_EN
    chk("t1_shadow", 64'(shadow), 64'h0000_0000_00A5_5A5A);
`endif

    // Lane 1, all ones
    mon_clear();
    pulse(32'h80FF_FFFF);
    repeat (210) @(posedge clk); #1;
    chk("t2_rises", 64'(rises[1]), 64'd24);
    chk("t2_word", cap[1] & 64'hFF_FFFF, 64'hFF_FFFF);
    chk("t2_lane0_quiet", 64'(act_cnt[0]), 64'd0);
    chk("t2_min_setup", 64'(min_setup[1]), 64'd4);

    // Overrun at cycle 50
    mon_clear();
    pulse(32'h0012_3456);
    repeat (49) @(posedge clk); #1;
    pulse(32'h80AB_CDEF);
    @(negedge clk);
    chk("t3_overrun", 64'(status), 64'd3);
    repeat (160) @(posedge clk); #1;
    chk("t3_word", cap[0] & 64'hFF_FFFF, 64'h12_3456);
    chk("t3_rises", 64'(rises[0]), 64'd24);
    chk("t3_lane1_quiet", 64'(act_cnt[1]), 64'd0);

    // Clear flags, then back-to-back strobe in the final busy cycle
    mon_clear();
    pulse(32'h4000_0F0F);
    @(negedge clk);
    chk("t3_clear", 64'(status), 64'd1);
    repeat (203) @(posedge clk); #1;
    pulse(32'h00C3_C3C3);
    @(negedge clk);
    chk("t4_busy_held", 64'(status), 64'd1);
    repeat (210) @(posedge clk); #1;
    chk("t4_busy_cycles", 64'(busy_cnt), 64'd408);
    chk("t4_busy_falls", 64'(busy_falls), 64'd1);
    chk("t4_rises", 64'(rises[0]), 64'd48);
    chk("t4_words", cap[0] & 64'hFFFF_FFFF_FFFF, 64'h000F_0FC3_C3C3);

    // Reset at bit 10
    mon_clear();
    pulse(32'h00FF_FFFF);
    repeat (82) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_async_pins", 64'({spi_clk, spi_sdi, spi_le}), 64'd0);
    chk("t5_async_status", 64'(status), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("t5_no_le", 64'(le_cnt[0]), 64'd0);
    chk("t5_rises", 64'(rises[0]), 64'd10);
`ifdef AFE_SPI_SHADOW_EN
    chk("t5_shadow", 64'(shadow), 64'd0);
`endif

    // Three-lane instance: index 3 rejected, index 2 accepted
    pulse2(32'hC000_0000);
    @(negedge clk);
    chk("t6_badsel", 64'(status2), 64'd4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_quiet", 64'({spi_clk2, spi_sdi2, spi_le2}), 64'd0);
    end
`ifdef AFE_SPI_SHADOW_EN
    chk("t6_shadow", 64'(shadow2), 64'd0);
`endif
    @(posedge clk); #1;
    pulse2(32'h8000_0001);
    @(negedge clk);
    chk("t6_accept", 64'(status2), 64'd5);
    repeat (4) @(negedge clk);
    chk("t6_lane2_sclk", 64'({spi_clk2, spi_sdi2, spi_le2}), 64'({3'b100, 3'b000, 3'b000}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
